mult_ctrl: RTL and testbench

- Control unit for the 16x16 shift-add multiplier datapath.
- Sits directly upstream of the 33-bit accumulator register and drives its Load, Sh and Ad strobes.
- Consumes the accumulator LSB (current multiplier bit, M) and counts shift iterations.
- Signals completion to the requester with a level Start/Done handshake.

---
 rtl/mult_ctrl.sv | 94 +++++++++
 tb/tb_mult_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencer for the 16x16 shift-add multiplier: drives the accumulator's
// Load/Sh/Ad strobes from the current multiplier bit M and counts shifts.
module mult_ctrl #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          St,
  input  logic          M,
  output logic          Load,
  output logic          Sh,
  output logic          Ad,
  output logic          Done,
  output logic          Busy,
  output logic [CW-1:0] Count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // Strobes decode straight from state and M: Ad must follow the bit that the
  // previous Load/Sh edge just exposed, so it cannot wait a cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    Load    = 1'b0;
    Sh      = 1'b0;
    Ad      = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (St) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        Load    = 1'b1;
        Busy    = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        Busy = 1'b1;
        if (M) begin
          Ad      = 1'b1;
          state_d = S_SHIFT;
        end else begin
          Sh      = 1'b1;
          count_d = count_q + CW'(1);
          state_d = (count_q == LAST_SHIFT) ? S_DONE : S_CHECK;
        end
      end
      S_SHIFT: begin
        Sh      = 1'b1;
        Busy    = 1'b1;
        count_d = count_q + CW'(1);
        state_d = (count_q == LAST_SHIFT) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        Done = 1'b1;
        // Hold the product until the requester drops St.
        if (!St) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural 33-bit accumulator closes the loop on M,
// and each operation is checked against plain arithmetic (product, popcount).
module tb_mult_ctrl;

  logic        Clk;
  logic        rst;
  logic        St;
  logic        M;
  logic        Load, Sh, Ad, Done, Busy;
  logic [4:0]  Count;

  logic [32:0] acc;
  logic [15:0] mplier, mcand;

  int checks = 0;
  int errors = 0;
  int nads, nsh;
  logic [4:0] prev_cnt;
  logic       prev_sh;
  logic       have_prev;

  mult_ctrl #(.N(16), .CW(5)) dut (
    .Clk   (Clk),
    .rst   (rst),
    .St    (St),
    .M     (M),
    .Load  (Load),
    .Sh    (Sh),
    .Ad    (Ad),
    .Done  (Done),
    .Busy  (Busy),
    .Count (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Accumulator datapath: Load, add into the upper 17 bits, logical shift right.
  always @(posedge Clk) begin
    if (Load)    acc <= {17'd0, mplier};
    else if (Ad) acc[32:16] <= {1'b0, acc[31:16]} + {1'b0, mcand};
    else if (Sh) acc <= acc >> 1;
  end
  assign M = acc[0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge, with the per-cycle strobe rules.
  task automatic tick();
    logic [4:0] exp_cnt;
    @(posedge Clk);
    #1;
    chk("strobe_onehot", 64'($onehot0({Load, Sh, Ad})), 64'd1);
    chk("busy_vs_strobes", Busy, Load | Sh | Ad);
    chk("done_not_busy", Done & Busy, 1'b0);
    chk("count_le_n", 64'(Count <= 5'd16), 64'd1);
    if (have_prev) begin
      exp_cnt = prev_sh ? prev_cnt + 5'd1 : (Load ? 5'd0 : prev_cnt);
      chk("count_step", Count, exp_cnt);
    end
    prev_cnt  = Count;
    prev_sh   = Sh;
    have_prev = 1'b1;
    nads += int'(Ad);
    nsh  += int'(Sh);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit rand_st, input bit hold);
    int e;
    mplier = a;
    mcand  = b;
    nads   = 0;
    nsh    = 0;
    St     = 1'b1;
    tick();
    chk("load_after_start", Load, 1'b1);
    e = 0;
    while (!Done && e < 60) begin
      if (rand_st) St = 1'($urandom % 2);
      tick();
      e++;
    end
    chk("done_latency", 64'(e), 64'(17 + $countones(a)));
    chk("ad_pulses", 64'(nads), 64'($countones(a)));
    chk("sh_pulses", 64'(nsh), 64'd16);
    chk("count_at_done", Count, 5'd16);
    chk("product", acc[31:0], 32'(a) * 32'(b));
    if (hold) begin
      St = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("hold_done", Done, 1'b1);
        chk("hold_no_load", Load, 1'b0);
      end
    end
    St = 1'b0;
    tick();
    chk("idle_done_low", Done, 1'b0);
    chk("idle_busy_low", Busy, 1'b0);
    chk("idle_no_load", Load, 1'b0);
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    St        = 1'b0;
    mplier    = '0;
    mcand     = '0;
    have_prev = 1'b0;
    prev_cnt  = '0;
    prev_sh   = 1'b0;
    nads      = 0;
    nsh       = 0;
    #2;
    chk("rst_outputs", {Load, Sh, Ad, Done, Busy}, 5'b0);
    chk("rst_count", Count, 5'd0);
    #10 rst = 1'b0;

    // Abort mid-CHECK at Count=7 and confirm the asynchronous return to idle.
    mplier = 16'hFFFF;
    mcand  = 16'h0101;
    St     = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (Count == 5'd7 && Ad) found = 1'b1;
    end
    chk("reach_check_cnt7", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {Load, Sh, Ad, Done, Busy}, 5'b0);
    chk("async_rst_count", Count, 5'd0);
    St = 1'b0;
    @(negedge Clk);
    rst       = 1'b0;
    have_prev = 1'b0;
    tick();
    chk("post_rst_idle", {Load, Sh, Ad, Done, Busy}, 5'b0);

    run_op(16'h0000, 16'h1234, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      run_op(16'($urandom), 16'($urandom), 1'b1, k[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
